// File: rtl/fft_pkg.sv
// fft_pkg: shared word widths, sequencer state encoding and state-to-strobe decode for the FFT butterfly block
package fft_pkg;
  localparam int DW = 8;
  localparam int CNT_W = 16;
  typedef enum logic [4:0] {
    IDLE, IN0, IN1, IN2, IN3, IN4, IN5,
    S0, S1, S2, S3, S4, S5, S6, S7, S8,
    OUT0, OUT1, OUT2, OUT3
  } state_t;
  function automatic logic [8:0] strobe_of(state_t s);
    return (s inside {[S0:S8]}) ? 9'b1 << (s - S0) : 9'b0;
  endfunction
endpackage

// File: rtl/fft_bfly_outser.sv
// fft_bfly_outser: 4-word butterfly result bank (cap_en/cap_idx/alu_res in) and dout/dout_valid/dout_ready serialiser (out_en/out_idx select, acc = word accepted)
module fft_bfly_outser
  import fft_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          cap_en,
  input  logic [1:0]    cap_idx,
  input  logic [DW-1:0] alu_res,
  input  logic          out_en,
  input  logic [1:0]    out_idx,
  input  logic          dout_ready,
  output logic [DW-1:0] dout,
  output logic          dout_valid,
  output logic          acc
);
  logic [DW-1:0] res_q [4];
  logic [DW-1:0] res_d [4];
  always_comb begin
    res_d = res_q;
    if (cap_en) res_d[cap_idx] = alu_res;
  end
  always_ff @(posedge clk) begin
    if (rst) res_q <= '{default: '0};
    else res_q <= res_d;
  end
  assign dout_valid = out_en;
  assign dout = out_en ? res_q[out_idx] : '0;
  assign acc = out_en & dout_ready;
endmodule

// File: rtl/fft_bfly_ctrl.sv
// fft_bfly_ctrl: radix-2 butterfly sequencer; loads reb,imb,rew,imw,rea,ima from din/din_valid, steps s00..s88 capturing alu_res into reg_alu and the result bank, streams dout with valid/ready, busy outside IDLE; FFT_BFLY_STALL_CNT_EN adds stall_cnt
module fft_bfly_ctrl
  import fft_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [DW-1:0]    din,
  input  logic             din_valid,
  input  logic [DW-1:0]    alu_res,
  output logic [DW-1:0]    reb,
  output logic [DW-1:0]    imb,
  output logic [DW-1:0]    rew,
  output logic [DW-1:0]    imw,
  output logic [DW-1:0]    rea,
  output logic [DW-1:0]    ima,
  output logic [DW-1:0]    reg_alu,
  output logic             s00,
  output logic             s11,
  output logic             s22,
  output logic             s33,
  output logic             s44,
  output logic             s55,
  output logic             s66,
  output logic             s77,
  output logic             s88,
  output logic [DW-1:0]    dout,
  output logic             dout_valid,
  input  logic             dout_ready,
  output logic             busy
`ifdef FFT_BFLY_STALL_CNT_EN
  ,
  output logic [CNT_W-1:0] stall_cnt
`endif
);
  state_t state_q, state_d;
  logic [DW-1:0] op_q [6];
  logic [DW-1:0] op_d [6];
  logic [DW-1:0] reg_alu_q, reg_alu_d;
  logic in_st, out_en, cap_en, acc, adv;
  logic [2:0] in_idx;
  logic [1:0] cap_idx, out_idx;
  assign in_st = state_q inside {[IN0:IN5]};
  assign in_idx = 3'(state_q - IN0);
  assign out_en = state_q inside {[OUT0:OUT3]};
  assign out_idx = 2'(state_q - OUT0);
  assign cap_en = state_q inside {S2, S3, S6, S7};
  assign cap_idx = {state_q inside {S6, S7}, state_q inside {S3, S7}};
  // compute states always advance; load and output states wait on their handshakes
  assign adv = state_q == IDLE ? start : in_st ? din_valid : out_en ? acc : 1'b1;
  always_comb begin
    op_d = op_q;
    if (in_st && din_valid) op_d[in_idx] = din;
    reg_alu_d = (state_q inside {[S0:S7]}) ? alu_res : reg_alu_q;
    state_d = !adv ? state_q : state_q == OUT3 ? IDLE : state_t'(state_q + 5'd1);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      op_q <= '{default: '0};
      reg_alu_q <= '0;
    end else begin
      state_q <= state_d;
      op_q <= op_d;
      reg_alu_q <= reg_alu_d;
    end
  end
  fft_bfly_outser u_outser (
    .clk(clk), .rst(rst), .cap_en(cap_en), .cap_idx(cap_idx), .alu_res(alu_res),
    .out_en(out_en), .out_idx(out_idx), .dout_ready(dout_ready),
    .dout(dout), .dout_valid(dout_valid), .acc(acc)
  );
  assign {reb, imb, rew, imw, rea, ima} = {op_q[0], op_q[1], op_q[2], op_q[3], op_q[4], op_q[5]};
  assign reg_alu = reg_alu_q;
  assign {s88, s77, s66, s55, s44, s33, s22, s11, s00} = strobe_of(state_q);
  assign busy = state_q != IDLE;
`ifdef FFT_BFLY_STALL_CNT_EN
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  assign stall_cnt_d = (state_q == IDLE && start) ? '0
                     : (dout_valid && !dout_ready && !(&stall_cnt_q)) ? stall_cnt_q + 1'b1
                     : stall_cnt_q;
  always_ff @(posedge clk) begin
    if (rst) stall_cnt_q <= '0;
    else stall_cnt_q <= stall_cnt_d;
  end
  assign stall_cnt = stall_cnt_q;
`endif
endmodule

// File: tb/tb_fft_bfly_ctrl.sv
// tb_fft_bfly_ctrl: scoreboard bench for fft_bfly_ctrl with directed operand/ALU vectors
module tb_fft_bfly_ctrl;
  logic clk = 0, rst = 1, start = 0, din_valid = 0, dout_ready = 1;
  logic [7:0] din = 0, alu_res, alu_base = 8'hA0;
  logic [7:0] reb, imb, rew, imw, rea, ima, reg_alu, dout;
  logic s00, s11, s22, s33, s44, s55, s66, s77, s88, dout_valid, busy;
  logic [8:0] stb;
`ifdef FFT_BFLY_STALL_CNT_EN
  logic [15:0] stall_cnt;
`endif
  int total = 0, bad = 0, cyc = 0, t0;
  logic [7:0] exp_q[$];
  logic [7:0] d1[6] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
  logic [7:0] d2[6] = '{8'h81, 8'h92, 8'hA3, 8'hB4, 8'hC5, 8'hD6};
  logic [7:0] d3[6] = '{8'h9A, 8'h9B, 8'h9C, 8'h9D, 8'h9E, 8'h9F};
  logic [7:0] d4[6] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20};

  fft_bfly_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .din(din), .din_valid(din_valid), .alu_res(alu_res),
    .reb(reb), .imb(imb), .rew(rew), .imw(imw), .rea(rea), .ima(ima), .reg_alu(reg_alu),
    .s00(s00), .s11(s11), .s22(s22), .s33(s33), .s44(s44), .s55(s55), .s66(s66), .s77(s77), .s88(s88),
    .dout(dout), .dout_valid(dout_valid), .dout_ready(dout_ready), .busy(busy)
`ifdef FFT_BFLY_STALL_CNT_EN
    , .stall_cnt(stall_cnt)
`endif
  );

  assign stb = {s88, s77, s66, s55, s44, s33, s22, s11, s00};
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always_comb begin
    alu_res = alu_base;
    for (int i = 0; i < 9; i++) if (stb[i]) alu_res = alu_base + 8'(i);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    check("onehot", 32'($countones(stb) <= 1), 1);
    if (dout_valid === 1'b1 && dout_ready) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL dout_extra: got %0h expected no word", dout);
      end else check("dout", dout, exp_q.pop_front());
    end
  end

  task automatic push_exp;
    exp_q.push_back(alu_base + 8'd2);
    exp_q.push_back(alu_base + 8'd3);
    exp_q.push_back(alu_base + 8'd6);
    exp_q.push_back(alu_base + 8'd7);
  endtask

  task automatic load(input logic [7:0] d[6], input int gap, input logic [7:0] prev_rew);
    start = 1;
    t0 = cyc;
    tick;
    start = 0;
    check("busy_in0", busy, 1);
`ifdef FFT_BFLY_STALL_CNT_EN
    check("stall_clr", stall_cnt, 0);
`endif
    for (int i = 0; i < 6; i++) begin
      if (i == 2 && gap > 0) begin
        din_valid = 0;
        din = 8'hEE;
        repeat (gap) tick;
        check("rew_hold", rew, prev_rew);
      end
      din = d[i];
      din_valid = 1;
      tick;
    end
    din_valid = 0;
    check("s00", s00, 1);
    check("s00_cyc", cyc - t0, 7 + gap);
    check("ops", {reb, imb, rew, imw, rea, ima}, 0);
  endtask

  task automatic check_ops(input logic [7:0] d[6]);
    check("reb", reb, d[0]); check("imb", imb, d[1]); check("rew", rew, d[2]);
    check("imw", imw, d[3]); check("rea", rea, d[4]); check("ima", ima, d[5]);
  endtask

  task automatic finish_run(input int gap, input int stall, input logic pulse);
    repeat (4) tick;
    check("s44", s44, 1);
    start = pulse;
    tick;
    start = 0;
    check("s55", s55, 1);
    repeat (3) tick;
    check("s88", s88, 1);
    check("s88_cyc", cyc - t0, 15 + gap);
    check("reg_alu", reg_alu, alu_base + 8'd7);
    tick;
    check("out0_valid", dout_valid, 1);
    check("out0_cyc", cyc - t0, 16 + gap);
    tick;
    if (stall > 0) begin
      dout_ready = 0;
      repeat (stall) begin
        tick;
        check("hold_dout", dout, alu_base + 8'd3);
        check("hold_valid", dout_valid, 1);
      end
      dout_ready = 1;
    end
    for (int k = 0; k < 20 && busy; k++) tick;
    check("idle", busy, 0);
    check("idle_cyc", cyc - t0, 20 + gap + stall);
`ifdef FFT_BFLY_STALL_CNT_EN
    check("stall_cnt", stall_cnt, stall);
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    tick;
    tick;
    rst = 0;
    check("rst_busy", busy, 0);
    check("rst_valid", dout_valid, 0);
    check("rst_dout", dout, 0);
    check("rst_stb", stb, 0);
    check("rst_ops", {reb, imb, rew, imw, rea, ima, reg_alu}, 0);
    alu_base = 8'hA0;
    push_exp;
    start = 1;
    t0 = cyc;
    tick;
    start = 0;
    for (int i = 0; i < 6; i++) begin din = d1[i]; din_valid = 1; tick; end
    din_valid = 0;
    check("s00", s00, 1);
    check("s00_cyc", cyc - t0, 7);
    check_ops(d1);
    finish_run(0, 0, 0);
    alu_base = 8'h50;
    push_exp;
    start = 1;
    t0 = cyc;
    tick;
    start = 0;
    for (int i = 0; i < 6; i++) begin
      if (i == 2) begin
        din_valid = 0;
        din = 8'hEE;
        repeat (3) tick;
        check("rew_hold", rew, 8'h33);
      end
      din = d2[i];
      din_valid = 1;
      tick;
    end
    din_valid = 0;
    check("s00", s00, 1);
    check("s00_cyc", cyc - t0, 10);
    check_ops(d2);
    finish_run(3, 5, 0);
    alu_base = 8'h30;
    start = 1;
    tick;
    start = 0;
    for (int i = 0; i < 6; i++) begin din = d3[i]; din_valid = 1; tick; end
    din_valid = 0;
    check_ops(d3);
    repeat (4) tick;
    check("s44_abort", s44, 1);
    rst = 1;
    tick;
    rst = 0;
    check("abort_busy", busy, 0);
    check("abort_stb", stb, 0);
    check("abort_valid", dout_valid, 0);
    check("abort_dout", dout, 0);
    check("abort_ops", {reb, imb, rew, imw, rea, ima, reg_alu}, 0);
    tick;
    alu_base = 8'hC0;
    push_exp;
    start = 1;
    t0 = cyc;
    tick;
    start = 0;
    for (int i = 0; i < 6; i++) begin din = d4[i]; din_valid = 1; tick; end
    din_valid = 0;
    check("s00", s00, 1);
    check_ops(d4);
    finish_run(0, 0, 1);
    repeat (3) tick;
    check("stay_idle", busy, 0);
    check("queue_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
